fetch_prefetch_queue: RTL

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/fetch_prefetch_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue:
// FSM state encoding and default PC constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam int DEFAULT_PC_STEP  = 4;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the prefetch queue.
// Combinational read of the head entry; flush empties the queue in one cycle.
// Only the pointers and count are reset; the storage array is not.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy control; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding-request fetch FSM
// (IDLE/FETCH/DROP) feeding a sync_fifo of {pc, instr} toward decode.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives while the queue is empty is presented to decode in the same cycle.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int                  PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic                      f_clk,
  input  logic                      f_rst,
  input  logic                      f_i_ce,
  input  logic                      f_i_redirect,
  input  logic [PC_WIDTH-1:0]       f_i_redirect_pc,
  output logic                      f_o_imem_req,
  output logic [PC_WIDTH-1:0]       f_o_imem_addr,
  input  logic                      f_i_imem_ack,
  input  logic [IWIDTH-1:0]         f_i_imem_data,
  output logic                      f_o_valid,
  output logic [IWIDTH-1:0]         f_o_instr,
  output logic [PC_WIDTH-1:0]       f_o_pc,
  input  logic                      f_i_ready,
  output logic [$clog2(DEPTH):0]    f_o_count
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e               state, state_n;
  logic [PC_WIDTH-1:0]        fetch_pc, fetch_pc_n;
  logic [PC_WIDTH-1:0]        drop_addr, drop_addr_n;
  logic                       push, pop, flush;
  logic [CW-1:0]              cnt, cnt_after;
  logic [PC_WIDTH+IWIDTH-1:0] head;
  logic                       head_vld;
  logic                       byp;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_WIDTH + IWIDTH)
  ) u_fifo (
    .clk   (f_clk),
    .rst   (f_rst),
    .flush (flush),
    .push  (push),
    .wdata ({fetch_pc, f_i_imem_data}),
    .pop   (pop),
    .rdata (head),
    .count (cnt)
  );

`ifdef FETCH_BYPASS_EN
  assign byp = (state == FETCH) && f_i_imem_ack && !f_i_redirect &&
               (cnt == '0) && !f_rst;
`else
  assign byp = 1'b0;
`endif

  assign head_vld = (cnt != '0) && !f_rst;

  // Decode-facing outputs; instr/pc forced to zero when nothing is valid.
  always_comb begin
    f_o_valid = head_vld || byp;
    f_o_instr = '0;
    f_o_pc    = '0;
    if (head_vld) begin
      f_o_pc    = head[PC_WIDTH+IWIDTH-1:IWIDTH];
      f_o_instr = head[IWIDTH-1:0];
    end else if (byp) begin
      f_o_pc    = fetch_pc;
      f_o_instr = f_i_imem_data;
    end
  end

  // Memory-side outputs; in DROP the abandoned request address stays held.
  always_comb begin
    f_o_imem_req  = !f_rst && ((state == FETCH) || (state == DROP));
    f_o_imem_addr = fetch_pc;
    if (f_rst)               f_o_imem_addr = RESET_PC;
    else if (state == DROP)  f_o_imem_addr = drop_addr;
    f_o_count = f_rst ? '0 : cnt;
  end

  // Next-state, PC and queue-control logic; redirect outranks push and pop.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    drop_addr_n = drop_addr;
    flush       = 1'b0;
    push        = 1'b0;
    pop         = (cnt != '0) && f_i_ready && !f_i_redirect;
    cnt_after   = cnt;
    if (f_i_redirect) begin
      flush      = 1'b1;
      fetch_pc_n = f_i_redirect_pc;
      unique case (state)
        IDLE:  state_n = f_i_ce ? FETCH : IDLE;
        FETCH: begin
          if (f_i_imem_ack) begin
            state_n = f_i_ce ? FETCH : IDLE;
          end else begin
            state_n     = DROP;
            drop_addr_n = fetch_pc;
          end
        end
        DROP:  if (f_i_imem_ack) state_n = f_i_ce ? FETCH : IDLE;
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: if (f_i_ce && (cnt < DEPTH_C)) state_n = FETCH;
        FETCH: begin
          if (f_i_imem_ack) begin
            push       = !(byp && f_i_ready);
            fetch_pc_n = fetch_pc + PC_WIDTH'(PC_STEP);
            cnt_after  = cnt + CW'(push) - CW'(pop);
            state_n    = (f_i_ce && (cnt_after < DEPTH_C)) ? FETCH : IDLE;
          end
        end
        DROP: if (f_i_imem_ack) state_n = f_i_ce ? FETCH : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge f_clk) begin
    if (f_rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      drop_addr <= drop_addr_n;
    end
  end

endmodule
